// File: rtl/x_mem_player_pkg.sv
// x_mem_player_pkg: shared widths and state encoding for the sample loader/player
package x_mem_player_pkg;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 2;
   localparam int SAMPLES_PER_BYTE = 4;
   localparam int DIV_W = 16;
   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
endpackage

// File: rtl/x_mem_player_if.sv
// x_mem_player_if: command, byte stream, RAM port and DAC signals of the player
interface x_mem_player_if;
   import x_mem_player_pkg::*;
   logic i_load, i_play, i_stop;
   logic [ADDR_W-1:0] i_len;
   logic [DIV_W-1:0] i_div;
   logic i_byte_valid;
   logic [7:0] i_byte;
   logic o_byte_ready;
   logic [ADDR_W-1:0] o_mem_addr;
   logic o_mem_we;
   logic [DATA_W-1:0] o_mem_wdata, i_mem_rdata;
   logic [DATA_W-1:0] o_dac;
   logic o_strobe, o_busy, o_done;
   modport master (
      output i_load, i_play, i_stop, i_len, i_div, i_byte_valid, i_byte, i_mem_rdata,
      input  o_byte_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_dac, o_strobe, o_busy, o_done
   );
   modport slave (
      input  i_load, i_play, i_stop, i_len, i_div, i_byte_valid, i_byte, i_mem_rdata,
      output o_byte_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_dac, o_strobe, o_busy, o_done
   );
endinterface

// File: rtl/x_mem_player_rate.sv
// x_mem_player_rate: free-running divider, tick every div+1 cycles once clear drops
module x_mem_player_rate
   import x_mem_player_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;
   assign tick = !clear && cnt == div;
   always_ff @(posedge i_clk or negedge i_nrst)
      if (!i_nrst) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/x_mem_player.sv
// x_mem_player: unpacks bytes into a 2048x2 RAM and plays them to a DAC at a divided rate;
// define X_MEM_PLAYER_LOOP_EN for looping playback instead of one-shot.
module x_mem_player
   import x_mem_player_pkg::*;
(
   input logic           i_clk,
   input logic           i_nrst,
   x_mem_player_if.slave bus
);
`ifdef X_MEM_PLAYER_LOOP_EN
   localparam logic LOOP = 1'b1;
`else
   localparam logic LOOP = 1'b0;
`endif
   state_t state, state_n;
   logic [ADDR_W-1:0] addr, len_q;
   logic [DIV_W-1:0] div_q;
   logic [7:0] sbuf;
   logic [2:0] cnt;
   logic [DATA_W-1:0] dac_q;
   logic fresh, strobe_q, done_q, tick, wr, last, adv, take;
   x_mem_player_rate u_rate (
      .i_clk (i_clk),
      .i_nrst(i_nrst),
      .clear (state != PLAY),
      .div   (div_q),
      .tick  (tick)
   );
   assign last = addr == len_q;
   assign adv  = tick && (LOOP || !last);
   assign take = bus.i_byte_valid && bus.o_byte_ready;
   always_ff @(posedge i_clk or negedge i_nrst)
      if (!i_nrst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.i_load ? LOAD : bus.i_play ? PLAY : IDLE;
         LOAD:    state_n = (bus.i_stop || (wr && last)) ? IDLE : LOAD;
         PLAY:    state_n = (bus.i_stop || done_q) ? IDLE : PLAY;
         default: state_n = IDLE;
      endcase
   end
   // the DAC bypasses its holding register on strobe cycles so the RAM's one-cycle read lines up
   always_comb begin
      wr               = state == LOAD && cnt != '0 && !bus.i_stop;
      bus.o_byte_ready = state == LOAD && cnt == '0;
      bus.o_mem_we     = wr;
      bus.o_mem_wdata  = wr ? sbuf[DATA_W-1:0] : '0;
      bus.o_mem_addr   = addr;
      bus.o_busy       = state != IDLE;
      bus.o_done       = (wr && last) || done_q;
      bus.o_strobe     = strobe_q;
      bus.o_dac        = strobe_q ? bus.i_mem_rdata : dac_q;
   end
   always_ff @(posedge i_clk or negedge i_nrst)
      if (!i_nrst) begin
         addr     <= '0;
         len_q    <= '0;
         div_q    <= '0;
         sbuf     <= '0;
         cnt      <= '0;
         fresh    <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         dac_q    <= '0;
      end else begin
         if (state == IDLE && (bus.i_load || bus.i_play)) begin
            len_q <= bus.i_len;
            div_q <= bus.i_div;
         end
         addr     <= state_n == IDLE ? '0 : wr ? addr + 1'b1 : (state == PLAY && adv) ? (last ? '0 : addr + 1'b1) : addr;
         cnt      <= state_n != LOAD ? '0 : take ? 3'(SAMPLES_PER_BYTE) : wr ? cnt - 1'b1 : cnt;
         sbuf     <= take ? bus.i_byte : wr ? sbuf >> DATA_W : sbuf;
         fresh    <= state_n == PLAY && (state != PLAY || adv);
         strobe_q <= state == PLAY && fresh && !bus.i_stop;
         done_q   <= !LOOP && state == PLAY && fresh && last && !bus.i_stop;
         if (strobe_q) dac_q <= bus.i_mem_rdata;
      end
endmodule

// File: tb/tb_x_mem_player.sv
// tb_x_mem_player: randomized load/play runs against a sample-list reference model
module tb_x_mem_player;
   import x_mem_player_pkg::*;
`ifdef X_MEM_PLAYER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;
   x_mem_player_if bus ();
   x_mem_player dut (.i_clk(clk), .i_nrst(nrst), .bus(bus));
   logic [1:0] ram [2048];
   int ref_mem [2048];
   logic [7:0] byte_arr [512];
   int cyc = 0, total = 0, bad = 0, idle_bad = 0, ready_bad = 0, last_dac = 0, wmax = 0;
   int wr_cyc[$], wr_addr[$], wr_data[$], st_cyc[$], st_dac[$], dn_cyc[$], acc_cyc[$];
   always @(posedge clk) begin
      if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
      bus.i_mem_rdata <= ram[bus.o_mem_addr];
      cyc <= cyc + 1;
   end
   always @(negedge clk) begin
      if (bus.o_mem_we) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(int'(bus.o_mem_addr));
         wr_data.push_back(int'(bus.o_mem_wdata));
      end
      if (bus.o_strobe) begin
         st_cyc.push_back(cyc);
         st_dac.push_back(int'(bus.o_dac));
      end
      if (bus.o_done) dn_cyc.push_back(cyc);
      if (bus.i_byte_valid && bus.o_byte_ready) acc_cyc.push_back(cyc);
      if (!bus.o_busy && (bus.o_mem_addr != '0 || bus.o_mem_we)) idle_bad++;
      if (bus.o_mem_we && bus.o_byte_ready) ready_bad++;
   end
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_logs();
      wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      st_cyc.delete(); st_dac.delete(); dn_cyc.delete(); acc_cyc.delete();
   endtask
   task automatic reset_chk();
      chk("rst_ready", bus.o_byte_ready, 0);
      chk("rst_addr", int'(bus.o_mem_addr), 0);
      chk("rst_we", bus.o_mem_we, 0);
      chk("rst_wdata", int'(bus.o_mem_wdata), 0);
      chk("rst_dac", int'(bus.o_dac), 0);
      chk("rst_strobe", bus.o_strobe, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
   endtask
   task automatic do_load(input int len, input int nbytes, input int stop_k, input bit play_too, input bit play_mid);
      int idx, n_exp, s, stop_cyc, end_cyc, last_w;
      bit stopped;
      clear_logs();
      step();
      bus.i_load = 1; bus.i_play = play_too; bus.i_len = 11'(len); bus.i_div = 16'($urandom);
      step();
      bus.i_load = 0; bus.i_play = 0; bus.i_len = 11'($urandom);
      stopped = 0; stop_cyc = -1; end_cyc = -1;
      for (int t = 0; t < 4000; t++) begin
         idx = acc_cyc.size();
         bus.i_byte_valid = idx < nbytes && $urandom_range(0, 3) != 0;
         bus.i_byte = idx < nbytes ? byte_arr[idx] : 8'($urandom);
         bus.i_play = play_mid && t == 2;
         bus.i_stop = stop_k >= 0 && !stopped && wr_cyc.size() == stop_k;
         if (bus.i_stop) begin stopped = 1; stop_cyc = cyc; end
         @(negedge clk);
         if (!bus.o_busy) begin end_cyc = cyc; break; end
         step();
      end
      bus.i_byte_valid = 0; bus.i_play = 0; bus.i_stop = 0;
      n_exp = (stop_k >= 0 && stop_k <= len) ? stop_k : len + 1;
      chk("load_nwr", wr_cyc.size(), n_exp);
      for (int i = 0; i < n_exp; i++) begin
         s = (int'(byte_arr[i/4]) >> (2 * (i % 4))) & 3;
         ref_mem[i] = s;
         if (i < wr_cyc.size()) begin
            chk("wr_addr", wr_addr[i], i);
            chk("wr_data", wr_data[i], s);
            chk("wr_cyc", wr_cyc[i], (i/4 < acc_cyc.size()) ? acc_cyc[i/4] + 1 + i % 4 : -1);
         end
      end
      if (n_exp > wmax) wmax = n_exp;
      if (stopped) begin
         chk("load_abort_ndone", dn_cyc.size(), 0);
         chk("load_abort_end", end_cyc, stop_cyc + 1);
      end else begin
         last_w = (len/4 < acc_cyc.size()) ? acc_cyc[len/4] + 1 + len % 4 : -1;
         chk("load_nacc", acc_cyc.size(), len/4 + 1);
         chk("load_ndone", dn_cyc.size(), 1);
         chk("load_done_cyc", dn_cyc.size() > 0 ? dn_cyc[0] : -1, last_w);
         chk("load_end", end_cyc, last_w + 1);
      end
      if (play_too || play_mid) begin
         repeat (3) step();
         chk("play_ignored_busy", bus.o_busy, 0);
         chk("play_ignored_st", st_cyc.size(), 0);
      end
   endtask
   task automatic do_play(input int len, input int div, input int stop_after);
      int e, lim, n, t, last_t, exp_end, stop_cyc, end_cyc;
      bit stopped, exp_done;
      clear_logs();
      if (LOOP && stop_after < 0) stop_after = 2 * (len + 1) + 1;
      step();
      bus.i_play = 1; bus.i_len = 11'(len); bus.i_div = 16'(div); e = cyc + 1;
      step();
      bus.i_play = 0; bus.i_load = 1; bus.i_len = 11'($urandom); bus.i_div = 16'($urandom);
      lim = (len + (stop_after > 0 ? stop_after : 0) + 4) * (div + 1) + 20;
      stopped = 0; stop_cyc = 1 << 30; end_cyc = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!bus.o_busy) begin end_cyc = cyc; break; end
         step();
         bus.i_load = 0;
         bus.i_stop = stop_after >= 0 && !stopped && st_cyc.size() == stop_after;
         if (bus.i_stop) begin stopped = 1; stop_cyc = cyc; end
      end
      bus.i_load = 0; bus.i_stop = 0;
      n = 0;
      for (int k = 0; k < 4096; k++) begin
         t = e + 1 + k * (div + 1);
         if ((!LOOP && k > len) || t > stop_cyc) break;
         if (k < st_cyc.size()) begin
            chk("st_cyc", st_cyc[k], t);
            chk("st_dac", st_dac[k], ref_mem[k % (len + 1)]);
         end
         n++;
      end
      chk("play_nst", st_cyc.size(), n);
      last_t = e + 1 + len * (div + 1);
      exp_done = !LOOP && last_t <= stop_cyc;
      exp_end = LOOP ? stop_cyc + 1 : (stop_cyc < last_t ? stop_cyc : last_t) + 1;
      chk("play_ndone", dn_cyc.size(), int'(exp_done));
      chk("play_done_cyc", dn_cyc.size() > 0 ? dn_cyc[0] : -1, exp_done ? last_t : -1);
      chk("play_end", end_cyc, exp_end);
      if (n > 0) last_dac = ref_mem[(n - 1) % (len + 1)];
      step(); step();
      chk("dac_hold", int'(bus.o_dac), last_dac);
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int len, nb, sk, pl, dv, sa;
      bus.i_load = 0; bus.i_play = 0; bus.i_stop = 0; bus.i_len = '0; bus.i_div = '0;
      bus.i_byte_valid = 0; bus.i_byte = '0;
      #3;
      reset_chk();
      step(); step();
      nrst = 1;
      byte_arr[0] = 8'hE4; byte_arr[1] = 8'h1B;
      do_load(7, 2, -1, 0, 0);
      do_play(7, 2, -1);
      do_play(3, 0, 6);
      for (int i = 0; i < 512; i++) byte_arr[i] = 8'($urandom);
      do_load(9, 3, -1, 1, 1);
      do_load(15, 4, 2, 0, 0);
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 512; i++) byte_arr[i] = 8'($urandom);
         len = it == 0 ? 0 : $urandom_range(1, 60);
         nb = len / 4 + 1 + $urandom_range(0, 1);
         sk = $urandom_range(0, 3) == 0 ? $urandom_range(0, len) : -1;
         do_load(len, nb, sk, 0, 0);
         pl = $urandom_range(0, wmax - 1);
         dv = $urandom_range(0, 4);
         sa = $urandom_range(0, 3) == 0 ? $urandom_range(0, pl) : -1;
         do_play(pl, dv, sa);
      end
      step();
      bus.i_play = 1; bus.i_len = 11'(wmax - 1); bus.i_div = 16'd3;
      step();
      bus.i_play = 0;
      repeat (15) step();
      #2 nrst = 0;
      #1 reset_chk();
      step(); step();
      nrst = 1;
      last_dac = 0;
      do_play(4, 1, -1);
      chk("idle_addr_we", idle_bad, 0);
      chk("ready_unpack", ready_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
